// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyph table,
// the all-off pattern and the width helper for the PWM threshold.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low patterns, bit6 = g ... bit0 = a; entry n is the glyph for hex n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic int thr_width(input int refresh_div, input int bright_bits);
    return $clog2(refresh_div) + bright_bits + 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  import seven_seg_pkg::*;

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment controller with frame-synchronised loading,
// per-digit enables, leading-zero blanking and PWM brightness.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_BITS = 3,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         enable,
  input  logic                          load,
  input  logic                          blank_lz,
  input  logic [BRIGHT_BITS-1:0]        brightness,
  output logic [6:0]                    sevenSeg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);
  import seven_seg_pkg::*;

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int TW    = thr_width(REFRESH_DIV, BRIGHT_BITS);
  localparam logic INV = (ACTIVE_LOW == 0);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]            SEG_IDLE   = SEG_OFF ^ {7{INV}};
  localparam logic [NUM_DIGITS-1:0] AN_IDLE    = {NUM_DIGITS{~INV}};

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic             presc_tc;
  logic             commit;

  logic [4*NUM_DIGITS-1:0] pend_dig, shad_dig;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_en, shad_dp, shad_en;
  logic                    pend_v;

  assign presc_tc = (presc == PRESC_LAST);
  assign commit   = presc_tc && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc_tc) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A load on the commit edge bypasses pending so the newest data wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
      pend_v   <= 1'b0;
      shad_dig <= '0;
      shad_dp  <= '0;
      shad_en  <= '0;
    end else if (commit) begin
      if (load) begin
        shad_dig <= digits;
        shad_dp  <= dp_in;
        shad_en  <= enable;
      end else if (pend_v) begin
        shad_dig <= pend_dig;
        shad_dp  <= pend_dp;
        shad_en  <= pend_en;
      end
      pend_v <= 1'b0;
    end else if (load) begin
      pend_dig <= digits;
      pend_dp  <= dp_in;
      pend_en  <= enable;
      pend_v   <= 1'b1;
    end
  end

  // Stage p0: decode the digit currently in its slot from the shadow copy.
  logic [IDX_W+1:0]       nib_base_p0;
  logic [3:0]             nib_p0;
  logic [6:0]             seg_p0;
  logic [NUM_DIGITS-1:0]  blank_p0;
  logic [NUM_DIGITS-1:0]  sel_p0;
  logic [TW-1:0]          thr_p0;
  logic                   upper_zero;
  logic                   lit_p0;

  assign nib_base_p0 = {idx, 2'b00};
  assign nib_p0      = shad_dig[nib_base_p0 +: 4];

  hex_to_seg u_dec (
    .nib (nib_p0),
    .seg (seg_p0)
  );

  // Walk from the top digit down; disabled digits above do not stop blanking.
  always_comb begin
    blank_p0   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      blank_p0[i] = blank_lz && (i != 0) && (shad_dig[4*i +: 4] == 4'h0) && upper_zero;
      upper_zero  = upper_zero && (!shad_en[i] || (shad_dig[4*i +: 4] == 4'h0));
    end
  end

  always_comb begin
    sel_p0      = '0;
    sel_p0[idx] = 1'b1;
  end

  assign thr_p0 = ((TW'(brightness) + TW'(1)) * TW'(REFRESH_DIV)) >> BRIGHT_BITS;
  assign lit_p0 = shad_en[idx] && !blank_p0[idx] && (TW'(presc) < thr_p0);

  // Stage p1: registered pins with polarity applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sevenSeg   <= SEG_IDLE;
      dp         <= ~INV;
      anode      <= AN_IDLE;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      scan_idx   <= idx;
      frame_done <= commit;
      if (lit_p0) begin
        sevenSeg <= seg_p0 ^ {7{INV}};
        dp       <= ~shad_dp[idx] ^ INV;
        anode    <= ~sel_p0 ^ {NUM_DIGITS{INV}};
      end else begin
        sevenSeg <= SEG_IDLE;
        dp       <= ~INV;
        anode    <= AN_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: an active-low and an active-high instance share
// stimulus and are compared every cycle against a frame-level reference model.
module tb_seven_seg_scan;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BB = 3;
  localparam int F  = N * RD;

  localparam logic [6:0] SCAN_SEG [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
  localparam logic [3:0] SCAN_AN  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dp_in, enable;
  logic        load, blank_lz;
  logic [2:0]  brightness;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  logic [3:0] an_a, an_b;
  logic [1:0] idx_a, idx_b;

  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_BITS(BB), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .enable(enable),
    .load(load), .blank_lz(blank_lz), .brightness(brightness),
    .sevenSeg(seg_a), .dp(dp_a), .anode(an_a), .scan_idx(idx_a), .frame_done(fd_a));

  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_BITS(BB), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .enable(enable),
    .load(load), .blank_lz(blank_lz), .brightness(brightness),
    .sevenSeg(seg_b), .dp(dp_b), .anode(an_b), .scan_idx(idx_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int c = 0;
  logic [15:0] sh_dig, pd_dig;
  logic [3:0]  sh_dp, sh_en, pd_dp, pd_en;
  bit          pv;
  int          on_a [4];
  int          on_b [4];
  int          fd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pattern(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit blanked(input int i);
    if (!blank_lz || i == 0) return 1'b0;
    for (int j = i; j < N; j++)
      if ((j == i || sh_en[j]) && sh_dig[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    for (int i = 0; i < N; i++)
      r[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    return r;
  endfunction

  task automatic tick();
    int presc, idx, thr;
    bit lit, commit;
    logic [3:0] an;
    logic [6:0] sg;
    logic d;
    presc  = c % RD;
    idx    = (c / RD) % N;
    thr    = ((int'(brightness) + 1) * RD) >> BB;
    lit    = sh_en[idx] && !blanked(idx) && (presc < thr);
    an     = lit ? ~(4'b0001 << idx) : 4'hF;
    sg     = lit ? pattern(sh_dig[4*idx +: 4]) : 7'h7F;
    d      = lit ? ~sh_dp[idx] : 1'b1;
    commit = ((c + 1) % F) == 0;
    @(posedge clk);
    if (commit) begin
      if (load) begin
        sh_dig = digits; sh_dp = dp_in; sh_en = enable;
      end else if (pv) begin
        sh_dig = pd_dig; sh_dp = pd_dp; sh_en = pd_en;
      end
      pv = 1'b0;
    end else if (load) begin
      pd_dig = digits; pd_dp = dp_in; pd_en = enable; pv = 1'b1;
    end
    c++;
    #1;
    chk("dut_a", {an_a, seg_a, dp_a, idx_a, fd_a}, {an, sg, d, 2'(idx), commit});
    chk("dut_b", {an_b, seg_b, dp_b, idx_b, fd_b}, {~an, ~sg, ~d, 2'(idx), commit});
    for (int i = 0; i < N; i++) begin
      if (!an_a[i]) on_a[i]++;
      if (an_b[i])  on_b[i]++;
    end
    if (fd_a) fd_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_a", {an_a, seg_a, dp_a, idx_a, fd_a}, {4'hF, 7'h7F, 1'b1, 2'b00, 1'b0});
    chk("rst_b", {an_b, seg_b, dp_b, idx_b, fd_b}, 15'h0);
    digits = 16'h8888; enable = 4'hF; load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", {an_a, seg_a, dp_a, idx_a, fd_a}, {4'hF, 7'h7F, 1'b1, 2'b00, 1'b0});
    load = 1'b0;
    reset = 1'b0;
    sh_dig = '0; sh_dp = '0; sh_en = '0;
    pd_dig = '0; pd_dp = '0; pd_en = '0; pv = 1'b0;
    c = 0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    digits = d; dp_in = p; enable = e; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run_to_commit();
    tick();
    for (int k = 0; k < F && (c % F) != 0; k++) tick();
  endtask

  task automatic run_to_precommit();
    for (int k = 0; k < F && ((c + 1) % F) != 0; k++) tick();
  endtask

  task automatic measure_frame();
    run_to_commit();
    for (int i = 0; i < N; i++) begin on_a[i] = 0; on_b[i] = 0; end
    fd_cnt = 0;
    repeat (F) tick();
  endtask

  initial begin
    digits = '0; dp_in = '0; enable = '0; load = 1'b0; blank_lz = 1'b0; brightness = 3'd7;
    #3;
    do_reset();
    repeat (40) tick();

    // basic scan of 12AF
    do_load(16'h12AF, 4'b0000, 4'hF);
    run_to_commit();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("scan_seg", seg_a, SCAN_SEG[k]);
      chk("scan_an", an_a, SCAN_AN[k]);
      repeat (7) tick();
    end
    fd_cnt = 0;
    repeat (3 * F) tick();
    chk("frame_done_cnt", fd_cnt, 3);

    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0000, 4'hF);
    measure_frame();
    chk("blank5_d0", on_a[0], 8);
    chk("blank5_hi", on_a[1] + on_a[2] + on_a[3], 0);
    tick();
    chk("blank5_seg", seg_a, 7'b0010010);
    do_load(16'h0000, 4'b0000, 4'hF);
    measure_frame();
    chk("blank0_d0", on_a[0], 8);
    tick();
    chk("blank0_seg", seg_a, 7'b1000000);
    do_load(16'h0305, 4'b0000, 4'hF);
    measure_frame();
    chk("blank305_d3", on_a[3], 0);
    chk("blank305_d2", on_a[2], 8);
    chk("blank305_d1", on_a[1], 8);
    chk("blank305_d0", on_a[0], 8);

    // PWM duty per slot
    blank_lz = 1'b0;
    do_load(16'h12AF, 4'b1010, 4'hF);
    for (int b = 0; b < 8; b += 1) begin
      if (b != 0 && b != 3 && b != 7) continue;
      brightness = 3'(b);
      measure_frame();
      for (int i = 0; i < N; i++) chk("pwm_on", on_a[i], b + 1);
    end

    // tear-free loading
    brightness = 3'd7;
    do_load(16'h1111, 4'b0000, 4'hF);
    run_to_commit();
    repeat (16) tick();
    digits = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (8) tick();
    chk("tear_d3_seg", seg_a, 7'b1111001);
    chk("tear_d3_an", an_a, 4'b0111);
    repeat (6) tick();
    tick();
    chk("tear_fd", fd_a, 1'b1);
    tick();
    chk("tear_new", seg_a, 7'b0100100);
    run_to_precommit();
    digits = 16'h3333; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("commit_load", seg_a, 7'b0110000);
    do_load(16'h4444, 4'b0000, 4'hF);
    run_to_precommit();
    digits = 16'h5555; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("newest_wins", seg_a, 7'b0010010);

    // polarity and enables
    do_load(16'h8888, 4'b0101, 4'b0101);
    measure_frame();
    chk("pol_on0", on_b[0], 8);
    chk("pol_on1", on_b[1], 0);
    chk("pol_on2", on_b[2], 8);
    chk("pol_on3", on_b[3], 0);
    tick();
    chk("pol_seg8", seg_b, 7'b1111111);
    chk("pol_dp", dp_b, 1'b1);
    repeat (8) tick();
    chk("pol_idle_seg", seg_b, 7'b0000000);
    chk("pol_idle_an", an_b, 4'b0000);

    // randomized traffic with a mid-frame reset
    for (int n = 0; n < 900; n++) begin
      if (n == 450) do_reset();
      if ($urandom_range(0, 11) == 0) begin
        digits = rand_digits();
        dp_in  = 4'($urandom_range(0, 15));
        enable = 4'($urandom_range(0, 15));
        load   = 1'b1;
      end
      if ($urandom_range(0, 40) == 0) brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) blank_lz = 1'($urandom_range(0, 1));
      tick();
      load = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
